copy_engine_rd_engine: RTL and testbench
========================================

Name: copy_engine_rd_engine

Overview:
- Read half of the copy engine, directly downstream of the host-memory AXI-MM port that the top-level AFU hands to copy_engine_top.
- Accepts one copy command at a time (source line address, line count) and splits it into AXI-MM read bursts on the AR channel.
- Consumes R beats into an internal buffer and forwards them, in order, as a ready/valid line stream to the write engine.
- Credit-based issue: r_ready never needs to deassert.

Parameters:
- ADDR_WIDTH, 64, byte address width of AR.
- DATA_WIDTH, 512, line width in bits; DATA_BYTES = DATA_WIDTH/8.
- BURST_CNT_WIDTH, 8, width of ar_len (AXI len = beats-1).
- MAX_BURST_LINES, 64, max beats per AR; must be <= 2**BURST_CNT_WIDTH.
- FIFO_DEPTH, 128, line buffer depth = read credits; must be >= MAX_BURST_LINES, power of 2.

Ports:
- clk  in  1  clock, the host channel clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_WIDTH  source byte address, DATA_BYTES-aligned
- cmd_num_lines  in  32  lines to read
- ar_valid  out  1
- ar_ready  in  1
- ar_addr  out  ADDR_WIDTH
- ar_len  out  BURST_CNT_WIDTH
- r_valid  in  1
- r_ready  out  1  constant 1 out of reset
- r_data  in  DATA_WIDTH
- r_resp  in  2  AXI response
- r_last  in  1  ignored; burst accounting is by credit
- out_valid  out  1
- out_ready  in  1
- out_data  out  DATA_WIDTH
- out_last  out  1  final line of command
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on command completion
- err  out  1  sticky, any non-OKAY r_resp in current/last command
- perf_cycles  out  32  see Optional Feature

Behaviour:
- Reset values: cmd_ready=0 while reset_n=0, then 1 in IDLE. ar_valid=0, out_valid=0, done=0, err=0, busy=0, perf_cycles=0. Credits=FIFO_DEPTH; FIFO empty.
- States:
  - IDLE: on cmd handshake, latch addr and remaining=cmd_num_lines, clear err. If num_lines==0, pulse done next cycle and stay in IDLE. Otherwise go to ISSUE.
  - ISSUE: burst = min(remaining, MAX_BURST_LINES). ar_valid=1 only when credits >= burst. ar_addr/ar_len are stable while ar_valid && !ar_ready.
  - On AR handshake: addr += burst*DATA_BYTES; remaining -= burst; credits -= burst. Go to DRAIN when remaining becomes 0.
  - DRAIN: wait for the out handshake with out_last=1, then pulse done the same cycle the state returns to IDLE.
- Credits:
  - Incremented by 1 per out handshake.
  - Simultaneous AR issue and out handshake in the same cycle nets both changes.
  - Credits never exceed FIFO_DEPTH.
- R beats:
  - Every r_valid beat is written to the FIFO.
  - An r_valid while the FIFO is full is a protocol violation; a simulation assertion fires.
- Ordering: responses are in-order; no AXI ID is used.
- Output stream:
  - out_valid = FIFO not empty; FIFO has first-word-fall-through.
  - out_last asserted when delivered count == num_lines-1.
  - Delivered count is 32-bit and resets per command.
- Errors: r_resp != 0 sets err. The data is still forwarded. err holds until the next command is accepted.
- Address arithmetic is modulo 2**ADDR_WIDTH (wrap without error).
- Reset mid-command: all state returns to reset values, FIFO flushed, no done pulse. In-flight host responses are discarded by the platform reset.

Optional Feature:
- Macro COPY_ENGINE_RD_PERF_CNT_EN.
- Defined: perf_cycles counts cycles with busy=1, saturating at 2**32-1, cleared on cmd accept.
- Undefined: perf_cycles tied to 0; no counter logic.

Decomposition:
- Package copy_engine_pkg holds:
  - t_rd_state enum {IDLE, ISSUE, DRAIN}
  - t_line_addr
  - AXI_RESP_OKAY constant
  - line-count typedef (32-bit)
- Sub-module copy_engine_line_fifo: synchronous FWFT FIFO with depth FIFO_DEPTH, width DATA_WIDTH+1, exposing full/empty.

Test Plan:
1. cmd addr 0x1000, 1 line -> one AR (addr 0x1000, len 0); one out beat with out_last=1; done 1 cycle after the out handshake.
2. cmd addr 0x0, 200 lines, defaults -> ARs at 0x0/0x1000/0x2000/0x3000 with len 63/63/63/7; 200 out beats in order, out_last only on beat 200.
3. Same cmd with out_ready=0 -> exactly 2 ARs issued (128 credits). Raise out_ready -> remaining ARs issue; no FIFO overflow assertion.
4. cmd_num_lines=0 -> no AR, done pulse on the cycle after accept, busy never 1.
5. r_resp=2'b10 on beat 3 of a 10-line cmd -> all 10 lines delivered, err=1 after done; next cmd accept clears err.
6. reset_n=0 for 1 cycle mid-burst -> next cycle all outputs at reset values; a fresh 4-line cmd completes normally.

Source files
------------

// File: rtl/copy_engine_pkg.sv
// Shared types and constants for the copy engine read path.
package copy_engine_pkg;

    // Read-engine FSM encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } t_rd_state;

    // Host byte address of a line.
    typedef logic [63:0] t_line_addr;

    // Line counts (command length, remaining, delivered).
    typedef logic [31:0] t_line_cnt;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Smaller of two line counts, used to size a burst.
    function automatic t_line_cnt min_lines(input t_line_cnt a, input t_line_cnt b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/copy_engine_line_fifo.sv
// Synchronous first-word-fall-through line buffer with full/empty flags.
// The head entry is visible on rd_data whenever empty is low.
module copy_engine_line_fifo #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 513
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[PW-1:0]];

    // Pointer bookkeeping; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Line storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/copy_engine_rd_engine.sv
// Copy engine read half: splits a (line address, line count) command into
// AXI-MM read bursts, buffers the R beats and streams them out in order.
// Bursts are only issued when the line buffer has room for the whole burst,
// so R beats are always accepted.
// Optional build macro COPY_ENGINE_RD_PERF_CNT_EN enables the busy-cycle
// counter on perf_cycles; without it perf_cycles is constant zero.
module copy_engine_rd_engine
    import copy_engine_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 8,
    parameter int MAX_BURST_LINES = 64,
    parameter int FIFO_DEPTH      = 128
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [31:0]                cmd_num_lines,
    output logic                       ar_valid,
    input  logic                       ar_ready,
    output logic [ADDR_WIDTH-1:0]      ar_addr,
    output logic [BURST_CNT_WIDTH-1:0] ar_len,
    input  logic                       r_valid,
    output logic                       r_ready,
    input  logic [DATA_WIDTH-1:0]      r_data,
    input  logic [1:0]                 r_resp,
    input  logic                       r_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [31:0]                perf_cycles
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(DATA_BYTES);
    localparam int CRED_W     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);

    if (FIFO_DEPTH < MAX_BURST_LINES || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        MAX_BURST_LINES > 2 ** BURST_CNT_WIDTH) begin : g_bad_params
        $error("copy_engine_rd_engine: FIFO_DEPTH/MAX_BURST_LINES out of range");
    end

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    t_line_cnt             remaining;
    t_line_cnt             num_lines;
    t_line_cnt             delivered;
    t_line_cnt             burst;
    logic [CRED_W-1:0]     credits;
    logic                  err_q;
    logic                  done_q;
    logic                  cmd_hs;
    logic                  ar_hs;
    logic                  out_hs;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_wdata;
    logic [DATA_WIDTH:0]   fifo_rdata;
    logic                  unused_r_last;

    // Bursts are counted by credit, not by r_last.
    assign unused_r_last = r_last;

    assign burst     = min_lines(remaining, t_line_cnt'(MAX_BURST_LINES));
    assign cmd_ready = reset_n && (state == ST_IDLE);
    assign r_ready   = reset_n;
    assign ar_valid  = (state == ST_ISSUE) && (t_line_cnt'(credits) >= burst);
    assign ar_addr   = addr;
    assign ar_len    = BURST_CNT_WIDTH'(burst - 32'd1);
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[DATA_WIDTH-1:0];
    assign out_last  = out_valid && (delivered == num_lines - 32'd1);
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign ar_hs  = ar_valid && ar_ready;
    assign out_hs = out_valid && out_ready;

    // Each stored line carries a tag bit marking a non-OKAY response.
    assign fifo_wdata = {(r_resp != AXI_RESP_OKAY), r_data};

    copy_engine_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_line_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (r_valid && r_ready),
        .wr_data (fifo_wdata),
        .rd_en   (out_hs),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    r_beat_into_full_fifo: assert property (@(posedge clk) disable iff (!reset_n)
        !(r_valid && fifo_full));

    // Command FSM, credit pool, delivered-line count and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            num_lines <= '0;
            delivered <= '0;
            credits   <= CRED_W'(FIFO_DEPTH);
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            // Issue and return in the same cycle both apply.
            credits <= credits - (ar_hs ? CRED_W'(burst) : '0) + (out_hs ? CRED_W'(1) : '0);
            if (out_hs) begin
                delivered <= delivered + 32'd1;
                // Raised as the tagged line leaves, so it covers every line up to done.
                if (fifo_rdata[DATA_WIDTH]) err_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_num_lines;
                        num_lines <= cmd_num_lines;
                        delivered <= '0;
                        err_q     <= 1'b0;
                        if (cmd_num_lines == 32'd0) done_q <= 1'b1;
                        else                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ar_hs) begin
                        addr      <= addr + (ADDR_WIDTH'(burst) << BYTE_SHIFT);
                        remaining <= remaining - burst;
                        if (remaining == burst) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_hs && out_last) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef COPY_ENGINE_RD_PERF_CNT_EN
    logic [31:0] perf_q;

    // Busy-cycle counter, restarted per command and saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (cmd_hs) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_copy_engine_rd_engine.sv
// Bench for copy_engine_rd_engine: an AXI read slave, a line-level model of
// the expected bursts and output stream, and directed command scenarios.
module tb_copy_engine_rd_engine;

    localparam int MAXB  = 64;
    localparam int DEPTH = 128;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [63:0]  cmd_addr = '0;
    logic [31:0]  cmd_num_lines = '0;
    logic         ar_valid;
    logic         ar_ready = 1'b0;
    logic [63:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         r_valid = 1'b0;
    logic         r_ready;
    logic [511:0] r_data = '0;
    logic [1:0]   r_resp = 2'b00;
    logic         r_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [511:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;
    logic [31:0]  perf_cycles;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    copy_engine_rd_engine dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_num_lines (cmd_num_lines),
        .ar_valid      (ar_valid),
        .ar_ready      (ar_ready),
        .ar_addr       (ar_addr),
        .ar_len        (ar_len),
        .r_valid       (r_valid),
        .r_ready       (r_ready),
        .r_data        (r_data),
        .r_resp        (r_resp),
        .r_last        (r_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .perf_cycles   (perf_cycles)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_data(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Line contents the slave returns for a given byte address.
    function automatic logic [511:0] pat(input logic [63:0] a);
        logic [511:0] v;
        for (int k = 0; k < 8; k++) v[k*64 +: 64] = a + 64'(k) * 64'h0100_0000_0000_0001;
        return v;
    endfunction

    // ---------------- model and slave state ----------------
    logic [63:0]  exp_ar_addr[$];
    int           exp_ar_len[$];
    logic [511:0] exp_data[$];
    bit           exp_last[$];
    logic [511:0] rq_data[$];
    logic [1:0]   rq_resp[$];
    int  m_issued = 0, m_deliv = 0, m_fifo = 0;
    bit  m_busy = 0, m_done = 0, m_err = 0;
    int  ar_cnt = 0, out_cnt = 0, done_cnt = 0, beat_idx = 0;
    int  err_beat = -1, ar_mode = 0, rgap = 0;
    int  last_out_cyc = 0, done_cyc = 0, acc_cyc = 0;
    bit  busy_seen = 0;
    logic [63:0] ar_log_addr[8];
    int          ar_log_len[8];

    // Expected bursts and lines for a command, from the splitting rule.
    task automatic model_cmd(input logic [63:0] a, input int n);
        int rem;
        logic [63:0] pa;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete(); exp_last.delete();
        rem = n;
        pa  = a;
        while (rem > 0) begin
            int b;
            b = (rem > MAXB) ? MAXB : rem;
            exp_ar_addr.push_back(pa);
            exp_ar_len.push_back(b - 1);
            pa  = pa + 64'(b) * 64;
            rem = rem - b;
        end
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(pat(a + 64'(i) * 64));
            exp_last.push_back(i == n - 1);
        end
    endtask

    task automatic model_reset();
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete(); exp_last.delete();
        rq_data.delete(); rq_resp.delete();
        m_issued = 0; m_deliv = 0; m_fifo = 0;
        m_busy = 0; m_done = 0; m_err = 0;
    endtask

    // Slave drive and per-cycle comparison against the model.
    initial begin
        bit ar_hs, r_hs, out_hs, cmd_hs, exp_arv, nxt_done;
        forever begin
            @(negedge clk);
            if (rq_data.size() > 0 && (rgap == 0 || (cyc % 2) == 0)) begin
                r_valid = 1'b1; r_data = rq_data[0]; r_resp = rq_resp[0];
            end else begin
                r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
            end
            ar_ready = (ar_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
            #1;
            if (!reset_n) begin
                model_reset();
            end else begin
                exp_arv = m_busy && exp_ar_addr.size() > 0 &&
                          (m_issued - m_deliv + exp_ar_len[0] + 1 <= DEPTH);
                check("busy", busy, m_busy);
                check("done", done, m_done);
                check("cmd_ready", cmd_ready, !m_busy);
                check("r_ready", r_ready, 1);
                check("ar_valid", ar_valid, exp_arv);
                check("out_valid", out_valid, m_fifo > 0);
                if (ar_valid && exp_ar_addr.size() > 0) begin
                    check("ar_addr", ar_addr, exp_ar_addr[0]);
                    check("ar_len", ar_len, exp_ar_len[0]);
                end
                if (out_valid && exp_data.size() > 0) begin
                    check_data("out_data", out_data, exp_data[0]);
                    check("out_last", out_last, exp_last[0]);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("err_at_done", err, m_err);
                end
                if (busy) busy_seen = 1;

                ar_hs  = ar_valid && ar_ready;
                r_hs   = r_valid && r_ready;
                out_hs = out_valid && out_ready;
                cmd_hs = cmd_valid && cmd_ready;
                nxt_done = 0;
                if (ar_hs) begin
                    if (ar_cnt < 8) begin
                        ar_log_addr[ar_cnt] = ar_addr;
                        ar_log_len[ar_cnt]  = int'(ar_len);
                    end
                    ar_cnt++;
                    for (int j = 0; j <= int'(ar_len); j++) begin
                        rq_data.push_back(pat(ar_addr + 64'(j) * 64));
                        rq_resp.push_back((beat_idx == err_beat) ? 2'b10 : 2'b00);
                        beat_idx++;
                    end
                    if (exp_ar_addr.size() > 0) begin
                        m_issued += exp_ar_len[0] + 1;
                        void'(exp_ar_addr.pop_front());
                        void'(exp_ar_len.pop_front());
                    end
                end
                if (r_hs && rq_data.size() > 0) begin
                    if (rq_resp[0] != 2'b00) m_err = 1;
                    void'(rq_data.pop_front());
                    void'(rq_resp.pop_front());
                    m_fifo++;
                end
                if (out_hs) begin
                    out_cnt++;
                    last_out_cyc = cyc;
                    m_fifo--;
                    m_deliv++;
                    if (exp_data.size() > 0) begin
                        if (exp_last[0]) begin
                            m_busy   = 0;
                            nxt_done = 1;
                        end
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                    end
                end
                if (cmd_hs) begin
                    model_cmd(cmd_addr, int'(cmd_num_lines));
                    m_err = 0; m_issued = 0; m_deliv = 0;
                    beat_idx = 0;
                    acc_cyc  = cyc;
                    if (cmd_num_lines == 0) nxt_done = 1;
                    else                    m_busy   = 1;
                end
                m_done = nxt_done;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic clear_stats();
        ar_cnt = 0; out_cnt = 0; busy_seen = 0;
    endtask

    task automatic send_cmd(input logic [63:0] a, input int n);
        bit ok;
        ok = 0;
        @(negedge clk);
        cmd_addr = a; cmd_num_lines = 32'(n); cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (cmd_ready) ok = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL cmd_accept: not accepted within 50 cycles, expected acceptance");
        end
    endtask

    task automatic wait_done(input int start, input int budget, input string name);
        int i;
        i = 0;
        while (done_cnt == start && i < budget) begin
            @(negedge clk); #2;
            i++;
        end
        tests++;
        if (done_cnt == start) begin
            fails++;
            $display("FAIL %s: no done within %0d cycles, expected a done pulse", name, budget);
        end
    endtask

    initial begin
        int dc0;
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_ar_valid", ar_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_perf", perf_cycles, 0);
        #1 reset_n = 1'b1;

        // 1: single line
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'h1000, 1);
        wait_done(dc0, 100, "t1_done");
        check("t1_ar_cnt", ar_cnt, 1);
        check("t1_ar_addr", ar_log_addr[0], 64'h1000);
        check("t1_ar_len", ar_log_len[0], 0);
        check("t1_out_cnt", out_cnt, 1);
        check("t1_done_lat", done_cyc - last_out_cyc, 1);

        // 2: 200 lines with a stalling AR channel
        ar_mode = 1;
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'h0, 200);
        wait_done(dc0, 3000, "t2_done");
        check("t2_ar_cnt", ar_cnt, 4);
        check("t2_ar0_addr", ar_log_addr[0], 64'h0000);
        check("t2_ar1_addr", ar_log_addr[1], 64'h1000);
        check("t2_ar2_addr", ar_log_addr[2], 64'h2000);
        check("t2_ar3_addr", ar_log_addr[3], 64'h3000);
        check("t2_ar0_len", ar_log_len[0], 63);
        check("t2_ar1_len", ar_log_len[1], 63);
        check("t2_ar2_len", ar_log_len[2], 63);
        check("t2_ar3_len", ar_log_len[3], 7);
        check("t2_out_cnt", out_cnt, 200);
        ar_mode = 0;

        // 3: consumer stalled, credits limit issue to the buffer depth
        @(negedge clk);
        out_ready = 1'b0;
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'h10000, 200);
        repeat (300) @(negedge clk);
        #2;
        check("t3_ar_cnt_stalled", ar_cnt, 2);
        check("t3_out_valid_stalled", out_valid, 1);
        check("t3_busy_stalled", busy, 1);
        @(negedge clk);
        out_ready = 1'b1;
        wait_done(dc0, 3000, "t3_done");
        check("t3_ar_cnt", ar_cnt, 4);
        check("t3_out_cnt", out_cnt, 200);

        // 4: zero-length command
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'h2000, 0);
        wait_done(dc0, 20, "t4_done");
        repeat (3) @(negedge clk);
        check("t4_done_lat", done_cyc - acc_cyc, 1);
        check("t4_ar_cnt", ar_cnt, 0);
        check("t4_busy_seen", busy_seen, 0);

        // 5: error response on beat 3, then cleared by the next command
        rgap = 1; err_beat = 2;
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'h8000, 10);
        wait_done(dc0, 300, "t5_done");
        check("t5_err_after_done", err, 1);
        check("t5_out_cnt", out_cnt, 10);
        rgap = 0; err_beat = -1;
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'h9000, 4);
        #2;
        check("t5_err_cleared", err, 0);
        wait_done(dc0, 200, "t5b_done");
        check("t5b_err", err, 0);

        // 6: reset pulse mid-command, then a fresh command
        clear_stats();
        send_cmd(64'h4000, 200);
        for (int i = 0; i < 200 && ar_cnt < 2; i++) begin
            @(negedge clk); #2;
        end
        check("t6_ar_before_reset", ar_cnt, 2);
        dc0 = done_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("t6_cmd_ready", cmd_ready, 0);
        check("t6_ar_valid", ar_valid, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_done", done, 0);
        check("t6_err", err, 0);
        check("t6_busy", busy, 0);
        check("t6_perf", perf_cycles, 0);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_done_on_reset", done_cnt, dc0);
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'h5000, 4);
        wait_done(dc0, 200, "t6_done");
        check("t6_out_cnt", out_cnt, 4);

        // 7: address wraps modulo 2**64 between bursts
        clear_stats(); dc0 = done_cnt;
        send_cmd(64'hFFFF_FFFF_FFFF_F000, 70);
        wait_done(dc0, 1000, "t7_done");
        check("t7_ar_cnt", ar_cnt, 2);
        check("t7_ar1_addr", ar_log_addr[1], 64'h0);
        check("t7_ar1_len", ar_log_len[1], 5);
        check("t7_out_cnt", out_cnt, 70);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
